posit_encoder_pipe: RTL

Two-stage pipelined posit encoder. It takes the decoded fields of an adder result (sign, regime value k, exponent, normalised fraction, sticky) and packs them into an N-bit posit with round-to-nearest-even. It sits at the back end of the posit adder, after normalisation. It is the inverse of the leading-bit-detect/decode path: it generates the regime run (k+1 ones then a 0, or -k zeros then a 1) rather than measuring it.

---
 rtl/posit_encoder_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/posit_encoder_pipe.sv
// Two-stage pipelined posit encoder: builds the regime run from k, packs {regime, exp, frac}, rounds and signs.
// Define POSIT_ENC_RNE_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module posit_encoder_pipe #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [RS:0]   in_k,
  input  logic [ES-1:0] in_exp,
  input  logic [N-1:0]  in_frac,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);
  localparam int KW = RS + 1;
  localparam int TW = 2 * N + ES + 1;
  localparam int SW = $clog2(TW + 1);
  localparam logic [KW-1:0] K_HI  = KW'(N - 2);
  localparam logic [KW-1:0] K_LO  = KW'(-(N - 2));
  localparam logic [KW-1:0] K_MIN = KW'(-(N - 1));
  localparam logic [N-2:0]  MINPOS = {{(N - 2){1'b0}}, 1'b1};

  logic s1_valid, s2_valid, adv1, adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  logic          k_max, k_min, fill;
  logic [KW-1:0] k_c, run;
  logic [SW-1:0] shift;
  logic [TW-1:0] tmp, shifted;

  // A full-width run of fill bits is shifted so only run = L-1 copies stay ahead of the terminator.
  always_comb begin
    k_max   = $signed(in_k) >= $signed(K_HI);
    k_min   = $signed(in_k) <= $signed(K_MIN);
    k_c     = k_max ? K_HI : (k_min ? K_LO : in_k);
    fill    = ~k_c[KW-1];
    run     = fill ? (k_c + KW'(1)) : (KW'(0) - k_c);
    shift   = SW'(N) - SW'(run);
    tmp     = {{N{fill}}, ~fill, in_exp, in_frac};
    shifted = tmp << shift;
  end

  logic [2*N-1:0] s1_body;
  logic           s1_sticky, s1_sign, s1_zero, s1_nar, s1_max, s1_min;

  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_body   <= shifted[TW-1 -: 2*N];
      s1_sticky <= in_sticky | (|shifted[TW-2*N-1:0]);
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_nar    <= in_nar;
      s1_max    <= k_max;
      s1_min    <= k_min;
    end
  end

  logic [N-2:0] mag, mag_r, mag_f;
  logic         guard, sticky, round_up;
  logic [N-1:0] sum, res;

  always_comb begin
    mag    = s1_body[2*N-1 -: N-1];
    guard  = s1_body[N];
    sticky = (|s1_body[N-1:0]) | s1_sticky;
`ifdef POSIT_ENC_RNE_EN
    round_up = guard & (mag[0] | sticky);
`else
    round_up = 1'b0;
`endif
    sum = {1'b0, mag} + N'(round_up);
    // Rounding may neither wrap into NaR nor collapse to zero.
    if (sum[N-1])
      mag_r = '1;
    else if (sum[N-2:0] == '0)
      mag_r = MINPOS;
    else
      mag_r = sum[N-2:0];
    mag_f = s1_max ? '1 : (s1_min ? MINPOS : mag_r);
    res   = s1_sign ? (~{1'b0, mag_f} + N'(1)) : {1'b0, mag_f};
    if (s1_nar)
      res = {1'b1, {(N - 1){1'b0}}};
    else if (s1_zero)
      res = '0;
  end

`ifndef POSIT_ENC_RNE_EN
  logic unused_rnd;
  assign unused_rnd = guard | sticky;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_posit <= '0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) out_posit <= res;
    end
  end

endmodule
